led_counter_controller: RTL and testbench
=========================================

Name: led_counter_controller

Overview:
Run/pause/direction/speed controller for the 8-bit binary LED counter on the Alhambra II (12 MHz).
- Takes four raw push-buttons and debounces them.
- Sequences an internal prescaler and an 8-bit up/down counter, and drives the LEDs.
- Replaces the fixed 1 s free-running counter with a user-controlled one. It sits between the board pins and the LED bank.

Parameters:
- CLK_FREQ, 12_000_000: input clock frequency in Hz (documentation only; sets the TICK_CYCLES default).
- TICK_CYCLES, 12_000_000: clock cycles per count step at speed 0 (1 s). Must be ≥ 8.
- DEBOUNCE_CYCLES, 240_000: consecutive stable cycles needed to accept a button level (20 ms). Must be ≥ 2.
- COUNT_WIDTH, 8: counter and LED width.

Ports:
- CLK  in  1  system clock.
- RST  in  1  asynchronous reset, active-high.
- BTN_START  in  1  raw button, active-high; toggles run/pause.
- BTN_DIR  in  1  raw button, active-high; toggles count direction.
- BTN_SPEED  in  1  raw button, active-high; cycles the speed setting.
- BTN_CLR  in  1  raw button, active-high; clears the count and stops.
- LED_OUT  out  COUNT_WIDTH  current count value (registered).
- RUNNING  out  1  high in the RUN state.
- DIR_UP  out  1  1 = counting up, 0 = counting down.
- SPEED  out  2  current speed code, 0..3.

Behaviour:
- Reset (async, RST=1):
  - LED_OUT=0, state=IDLE, RUNNING=0, DIR_UP=1, SPEED=0.
  - Prescaler=0; all debouncer state cleared, with stable level=0.
- Debounce, per button:
  - 2-FF synchroniser, then a stability counter.
  - The stable level changes only after the synchronised input has differed from it for DEBOUNCE_CYCLES consecutive cycles. Any bounce restarts the count.
  - On a stable 0→1 transition, a one-cycle press pulse is generated. Release generates no pulse.
- Press latency: the outputs reflect a press no later than DEBOUNCE_CYCLES+3 cycles after the raw input rises and then holds.
- FSM states:
  - IDLE: count held, prescaler held at 0.
  - RUN: prescaler advances.
  - PAUSE: count and prescaler frozen.
- FSM transitions:
  - START press: IDLE→RUN, RUN→PAUSE, PAUSE→RUN. Resuming continues from the frozen prescaler value.
  - CLR press, from any state: →IDLE, count=0, prescaler=0. DIR_UP and SPEED are kept.
- Prescaler:
  - Period P = TICK_CYCLES >> SPEED (speeds 1 s, 0.5 s, 0.25 s, 0.125 s).
  - In RUN it counts 0..P-1. At P-1 it issues a one-cycle tick and returns to 0.
  - On entering RUN from IDLE, the first tick occurs P cycles later.
- Tick: count ±1 according to DIR_UP, modulo 2^COUNT_WIDTH (up: 255→0; down: 0→255). LED_OUT updates in the same edge as the count (it is the count register).
- DIR press: toggles DIR_UP in any state. The count is unchanged.
- SPEED press: SPEED = SPEED+1 mod 4 in any state. The prescaler resets to 0 so the new period starts cleanly.
- Simultaneous events, in priority order:
  1. CLR overrides START, DIR and SPEED effects on state, count and prescaler. DIR and SPEED toggles in the same cycle still apply.
  2. A tick uses the pre-toggle DIR_UP.
  3. A tick and a START press in the same cycle in RUN: the tick is applied, then the FSM goes to PAUSE.
  4. A tick and a SPEED press in the same cycle: the tick is applied and the prescaler is reset.
- Reset mid-run: immediate return to reset values. The debouncer discards partial counts.

Decomposition:
- Package led_ctrl_pkg:
  - state encoding: IDLE=2'd0, RUN=2'd1, PAUSE=2'd2;
  - speed code width of 2;
  - default constants CLK_FREQ_HZ=12_000_000 and DEBOUNCE_20MS=240_000.
- Sub-module btn_debounce, instantiated 4 times:
  - parameter DEBOUNCE_CYCLES;
  - ports CLK, RST, BTN_IN, LEVEL, PRESS.
- The top level contains the FSM, prescaler, counter and output registers.

Test Plan (TICK_CYCLES=16, DEBOUNCE_CYCLES=4):
- Reset, then START press held for 10 cycles → RUNNING=1. LED_OUT goes 0→1→2→3 at 16-cycle intervals, DIR_UP=1, SPEED=0.
- BTN_START toggling every cycle for 3 cycles, then low → no press pulse and the state stays IDLE. A clean hold of ≥4 stable cycles is accepted exactly once.
- Counting up from 254 in RUN → LED_OUT shows 255 then 0. DIR press at 0, then ticks → 255, 254. Ticks arrive every 16 cycles.
- SPEED pressed 3 times in RUN → SPEED=1, 2, 3 with tick spacing 8, 4, 2 cycles. A 4th press gives SPEED=0 and spacing 16.
- START in RUN with the prescaler at 10 → PAUSE, LED_OUT frozen for 100 cycles. START again → the next tick comes 6 cycles after resume.
- CLR and DIR pressed in the same cycle while RUN at count 37 → state IDLE, LED_OUT=0, DIR_UP toggled, SPEED kept. RST asserted mid-RUN → all outputs return to reset values asynchronously.

Source files
------------

// File: rtl/led_ctrl_pkg.sv
// Shared types and constants for the user-controlled LED counter.
// State encoding, speed code and button event bundles live here.
package led_ctrl_pkg;

  localparam int unsigned SPEED_W       = 2;
  localparam int unsigned CLK_FREQ_HZ   = 12_000_000;
  localparam int unsigned DEBOUNCE_20MS = 240_000;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2
  } state_t;

  typedef logic [SPEED_W-1:0] speed_t;

  // One bit per button, used for both debounced levels and press pulses
  typedef struct packed {
    logic start;
    logic dir;
    logic speed;
    logic clr;
  } btn_evt_t;

  // Count-step period in cycles: each speed step halves the base period
  function automatic int unsigned speed_period(input int unsigned base, input speed_t speed);
    return base >> speed;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Push-button conditioner: 2-FF synchroniser, stability counter, and a
// one-cycle pulse on each accepted rising level.
module btn_debounce
  import led_ctrl_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_20MS
) (
  input  logic CLK,
  input  logic RST,
  input  logic BTN_IN,
  output logic LEVEL,
  output logic PRESS
);

  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync_a;
  logic             sync_b;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      sync_a <= 1'b0;
      sync_b <= 1'b0;
    end else begin
      sync_a <= BTN_IN;
      sync_b <= sync_a;
    end
  end

  // Level flips only after DEBOUNCE_CYCLES consecutive disagreeing samples
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      cnt   <= '0;
      LEVEL <= 1'b0;
      PRESS <= 1'b0;
    end else begin
      PRESS <= 1'b0;
      if (sync_b == LEVEL) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        cnt   <= '0;
        LEVEL <= sync_b;
        PRESS <= sync_b;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/led_counter_controller.sv
// Run/pause/direction/speed controller for the 8-bit LED counter: four
// debounced buttons drive an FSM, a speed-scaled prescaler and the count.
module led_counter_controller
  import led_ctrl_pkg::*;
#(
  parameter int unsigned CLK_FREQ        = CLK_FREQ_HZ,
  parameter int unsigned TICK_CYCLES     = CLK_FREQ,
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_20MS,
  parameter int unsigned COUNT_WIDTH     = 8
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic                   BTN_START,
  input  logic                   BTN_DIR,
  input  logic                   BTN_SPEED,
  input  logic                   BTN_CLR,
  output logic [COUNT_WIDTH-1:0] LED_OUT,
  output logic                   RUNNING,
  output logic                   DIR_UP,
  output logic [SPEED_W-1:0]     SPEED
);

  localparam int unsigned PRESC_W = $clog2(TICK_CYCLES);

  btn_evt_t press;
  btn_evt_t unused_level;

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_start (
    .CLK(CLK), .RST(RST), .BTN_IN(BTN_START), .LEVEL(unused_level.start), .PRESS(press.start)
  );
  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_dir (
    .CLK(CLK), .RST(RST), .BTN_IN(BTN_DIR), .LEVEL(unused_level.dir), .PRESS(press.dir)
  );
  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_speed (
    .CLK(CLK), .RST(RST), .BTN_IN(BTN_SPEED), .LEVEL(unused_level.speed), .PRESS(press.speed)
  );
  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_clr (
    .CLK(CLK), .RST(RST), .BTN_IN(BTN_CLR), .LEVEL(unused_level.clr), .PRESS(press.clr)
  );

  state_t                 state;
  state_t                 state_nxt;
  logic [PRESC_W-1:0]     presc;
  logic [PRESC_W-1:0]     presc_nxt;
  logic [PRESC_W-1:0]     presc_last;
  logic                   tick;
  logic [COUNT_WIDTH-1:0] count_nxt;
  logic                   dir_nxt;
  speed_t                 speed_nxt;
  logic                   running_nxt;

  always_comb begin
    presc_last = PRESC_W'(speed_period(TICK_CYCLES, SPEED) - 1);
    tick       = (state == RUN) && (presc == presc_last);
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state <= IDLE;
    else     state <= state_nxt;
  end

  // CLR dominates START; START toggles between RUN and PAUSE
  always_comb begin
    state_nxt = state;
    if (press.clr) begin
      state_nxt = IDLE;
    end else if (press.start) begin
      case (state)
        IDLE:    state_nxt = RUN;
        RUN:     state_nxt = PAUSE;
        PAUSE:   state_nxt = RUN;
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Later assignments override earlier ones: tick, then SPEED restart, then CLR
  always_comb begin
    count_nxt   = LED_OUT;
    presc_nxt   = presc;
    dir_nxt     = DIR_UP ^ press.dir;
    speed_nxt   = SPEED + SPEED_W'(press.speed);
    running_nxt = (state_nxt == RUN);

    if (tick) begin
      count_nxt = DIR_UP ? LED_OUT + COUNT_WIDTH'(1) : LED_OUT - COUNT_WIDTH'(1);
    end
    if (state == RUN) begin
      presc_nxt = tick ? '0 : presc + PRESC_W'(1);
    end else if (state == IDLE) begin
      presc_nxt = '0;
    end
    if (press.speed) begin
      presc_nxt = '0;
    end
    if (press.clr) begin
      count_nxt = '0;
      presc_nxt = '0;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      presc   <= '0;
      LED_OUT <= '0;
      RUNNING <= 1'b0;
      DIR_UP  <= 1'b1;
      SPEED   <= '0;
    end else begin
      presc   <= presc_nxt;
      LED_OUT <= count_nxt;
      RUNNING <= running_nxt;
      DIR_UP  <= dir_nxt;
      SPEED   <= speed_nxt;
    end
  end

endmodule

// File: tb/tb_led_counter_controller.sv
// Scenario bench for led_counter_controller with short tick/debounce periods;
// LED changes are captured by a monitor and matched against expected values.
module tb_led_counter_controller;
  import led_ctrl_pkg::*;

  localparam int unsigned TICK = 16;
  localparam int unsigned DEB  = 4;
  localparam int unsigned CW   = 8;

  localparam logic [3:0] B_START = 4'b1000;
  localparam logic [3:0] B_DIR   = 4'b0100;
  localparam logic [3:0] B_SPEED = 4'b0010;
  localparam logic [3:0] B_CLR   = 4'b0001;

  logic          clk = 1'b0;
  logic          rst;
  logic          btn_start, btn_dir, btn_speed, btn_clr;
  logic [CW-1:0] led_out;
  logic          running, dir_up;
  logic [1:0]    speed;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  typedef struct {
    logic [CW-1:0] val;
    int            at;
  } obs_t;

  obs_t          obs_q[$];
  logic [CW-1:0] exp_q[$];
  logic [CW-1:0] last_led;
  logic [CW-1:0] m_led;
  int            prev_at;

  led_counter_controller #(
    .CLK_FREQ(TICK), .TICK_CYCLES(TICK), .DEBOUNCE_CYCLES(DEB), .COUNT_WIDTH(CW)
  ) dut (
    .CLK(clk), .RST(rst), .BTN_START(btn_start), .BTN_DIR(btn_dir),
    .BTN_SPEED(btn_speed), .BTN_CLR(btn_clr), .LED_OUT(led_out),
    .RUNNING(running), .DIR_UP(dir_up), .SPEED(speed)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  initial begin
    last_led = '0;
    forever begin
      @(posedge clk);
      #1;
      if (led_out !== last_led) begin
        obs_q.push_back('{led_out, cyc});
        last_led = led_out;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  task automatic tick_n(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press(input logic [3:0] m, input int hold);
    {btn_start, btn_dir, btn_speed, btn_clr} = m;
    repeat (hold) @(negedge clk);
    {btn_start, btn_dir, btn_speed, btn_clr} = 4'b0000;
  endtask

  task automatic wait_obs(input int n, input int budget, output bit ok);
    int k = 0;
    while (obs_q.size() < n && k < budget) begin
      @(negedge clk);
      k++;
    end
    ok = (obs_q.size() >= n);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    {btn_start, btn_dir, btn_speed, btn_clr} = 4'b0000;
    tick_n(3);
    n_checks++; if (led_out !== 8'd0) begin n_fail++; $display("FAIL reset_led: got %0d want 0", led_out); end
    n_checks++; if (running !== 1'b0) begin n_fail++; $display("FAIL reset_running: got %0d want 0", running); end
    n_checks++; if (dir_up !== 1'b1) begin n_fail++; $display("FAIL reset_dir: got %0d want 1", dir_up); end
    n_checks++; if (speed !== 2'd0) begin n_fail++; $display("FAIL reset_speed: got %0d want 0", speed); end
    rst = 1'b0;
    tick_n(2);
    obs_q.delete();
  endtask

  task automatic test_start_run();
    int t0;
    bit ok;
    obs_t o;
    logic [CW-1:0] e;
    t0 = cyc;
    press(B_START, 10);
    n_checks++; if (running !== 1'b1) begin n_fail++; $display("FAIL start_running: got %0d want 1", running); end
    exp_q.push_back(8'd1); exp_q.push_back(8'd2); exp_q.push_back(8'd3);
    wait_obs(3, 80, ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL start_ticks: got %0d changes want 3", obs_q.size()); end
    prev_at = t0;
    for (int i = 0; i < 3 && obs_q.size() > 0; i++) begin
      o = obs_q.pop_front();
      e = exp_q.pop_front();
      n_checks++; if (o.val !== e) begin n_fail++; $display("FAIL start_val%0d: got %0d want %0d", i, o.val, e); end
      n_checks++;
      if (o.at - prev_at != ((i == 0) ? 23 : 16)) begin
        n_fail++; $display("FAIL start_gap%0d: got %0d want %0d", i, o.at - prev_at, (i == 0) ? 23 : 16);
      end
      prev_at = o.at;
    end
    exp_q.delete();
    n_checks++; if (dir_up !== 1'b1) begin n_fail++; $display("FAIL start_dir: got %0d want 1", dir_up); end
    n_checks++; if (speed !== 2'd0) begin n_fail++; $display("FAIL start_speed: got %0d want 0", speed); end
  endtask

  task automatic test_debounce_glitch();
    int t0;
    bit ok;
    press(B_CLR, 10);
    n_checks++; if (running !== 1'b0) begin n_fail++; $display("FAIL clr_running: got %0d want 0", running); end
    n_checks++; if (led_out !== 8'd0) begin n_fail++; $display("FAIL clr_led: got %0d want 0", led_out); end
    tick_n(10);
    btn_start = 1'b1; tick_n(1);
    btn_start = 1'b0; tick_n(1);
    btn_start = 1'b1; tick_n(1);
    btn_start = 1'b0;
    tick_n(15);
    n_checks++; if (running !== 1'b0) begin n_fail++; $display("FAIL glitch_running: got %0d want 0", running); end
    obs_q.delete();
    t0 = cyc;
    press(B_START, 4);
    tick_n(20);
    n_checks++; if (running !== 1'b1) begin n_fail++; $display("FAIL clean_hold_running: got %0d want 1", running); end
    wait_obs(1, 20, ok);
    n_checks++;
    if (!ok) begin
      n_fail++; $display("FAIL clean_hold_tick: got no change want 1");
    end else if (obs_q[0].val !== 8'd1 || obs_q[0].at != t0 + 23) begin
      n_fail++; $display("FAIL clean_hold_tick: got %0d@%0d want 1@%0d", obs_q[0].val, obs_q[0].at - t0, 23);
    end
    obs_q.delete();
  endtask

  task automatic test_wrap();
    logic [CW-1:0] seq [0:8];
    int            plen [0:2];
    logic          dexp [0:2];
    int            idx;
    bit            ok;
    obs_t          o;
    logic [CW-1:0] e;
    seq  = '{8'd2, 8'd1, 8'd0, 8'd255, 8'd254, 8'd255, 8'd0, 8'd255, 8'd254};
    plen = '{4, 2, 2};
    dexp = '{1'b0, 1'b1, 1'b0};
    wait_obs(1, 40, ok);
    n_checks++;
    if (!ok || obs_q[0].val !== seq[0]) begin
      n_fail++; $display("FAIL wrap_sync: got %0d want %0d", ok ? obs_q[0].val : 8'hxx, seq[0]);
    end
    if (ok) prev_at = obs_q[0].at;
    obs_q.delete();
    idx = 1;
    for (int p = 0; p < 3; p++) begin
      for (int j = 0; j < plen[p]; j++) exp_q.push_back(seq[idx + j]);
      idx += plen[p];
      press(B_DIR, 10);
      n_checks++; if (dir_up !== dexp[p]) begin n_fail++; $display("FAIL wrap_dir%0d: got %0d want %0d", p, dir_up, dexp[p]); end
      wait_obs(plen[p], plen[p] * 16 + 16, ok);
      n_checks++; if (!ok) begin n_fail++; $display("FAIL wrap_ticks%0d: got %0d want %0d", p, obs_q.size(), plen[p]); end
      while (obs_q.size() > 0 && exp_q.size() > 0) begin
        o = obs_q.pop_front();
        e = exp_q.pop_front();
        n_checks++; if (o.val !== e) begin n_fail++; $display("FAIL wrap_val: got %0d want %0d", o.val, e); end
        n_checks++; if (o.at - prev_at != 16) begin n_fail++; $display("FAIL wrap_gap: got %0d want 16", o.at - prev_at); end
        prev_at = o.at;
      end
      exp_q.delete();
      obs_q.delete();
    end
    m_led = 8'd254;
  endtask

  task automatic test_speed();
    int   t_sync;
    int   per;
    bit   ok;
    obs_t o [0:2];
    obs_t d;
    for (int k = 0; k < 4; k++) begin
      per    = 16 >> ((k + 1) % 4);
      t_sync = prev_at;
      press(B_SPEED, 10);
      if (k == 0) begin
        wait_obs(1, 20, ok);
        n_checks++;
        if (!ok || obs_q[0].at != t_sync + 15) begin
          n_fail++; $display("FAIL speed_first_gap: got %0d want 15", ok ? obs_q[0].at - t_sync : -1);
        end
      end
      tick_n(10);
      while (obs_q.size() > 0) begin
        d = obs_q.pop_front();
        n_checks++; if (d.val !== m_led - 8'd1) begin n_fail++; $display("FAIL speed%0d_drain: got %0d want %0d", k, d.val, m_led - 8'd1); end
        m_led = m_led - 8'd1;
      end
      n_checks++; if (speed !== 2'((k + 1) % 4)) begin n_fail++; $display("FAIL speed%0d_code: got %0d want %0d", k, speed, (k + 1) % 4); end
      wait_obs(3, 3 * per + 8, ok);
      n_checks++; if (!ok) begin n_fail++; $display("FAIL speed%0d_ticks: got %0d want 3", k, obs_q.size()); end
      if (!ok) return;
      for (int i = 0; i < 3; i++) begin
        o[i] = obs_q.pop_front();
        n_checks++; if (o[i].val !== m_led - 8'd1) begin n_fail++; $display("FAIL speed%0d_val: got %0d want %0d", k, o[i].val, m_led - 8'd1); end
        m_led = m_led - 8'd1;
      end
      n_checks++;
      if (o[1].at - o[0].at != per || o[2].at - o[1].at != per) begin
        n_fail++; $display("FAIL speed%0d_spacing: got %0d,%0d want %0d", k, o[1].at - o[0].at, o[2].at - o[1].at, per);
      end
      prev_at = o[2].at;
    end
  endtask

  task automatic test_pause();
    int s;
    bit ok;
    tick_n(3);
    press(B_START, 10);
    n_checks++; if (running !== 1'b0) begin n_fail++; $display("FAIL pause_running: got %0d want 0", running); end
    obs_q.delete();
    tick_n(100);
    n_checks++; if (obs_q.size() != 0) begin n_fail++; $display("FAIL pause_frozen: got %0d changes want 0", obs_q.size()); end
    obs_q.delete();
    s = cyc;
    press(B_START, 10);
    n_checks++; if (running !== 1'b1) begin n_fail++; $display("FAIL resume_running: got %0d want 1", running); end
    wait_obs(1, 30, ok);
    n_checks++;
    if (!ok || obs_q[0].at != s + 13 || obs_q[0].val !== m_led - 8'd1) begin
      n_fail++;
      $display("FAIL resume_tick: got %0d@%0d want %0d@13", ok ? obs_q[0].val : 8'hxx, ok ? obs_q[0].at - s : -1, m_led - 8'd1);
    end
    obs_q.delete();
  endtask

  task automatic test_clr_dir();
    bit            ok;
    obs_t          o;
    logic [CW-1:0] e;
    press(B_CLR, 10);
    n_checks++; if (led_out !== 8'd0 || running !== 1'b0) begin n_fail++; $display("FAIL clr_pause: got %0d/%0d want 0/0", led_out, running); end
    tick_n(10);
    for (int i = 0; i < 3; i++) begin press(B_SPEED, 10); tick_n(10); end
    press(B_DIR, 10); tick_n(10);
    n_checks++; if (speed !== 2'd3 || dir_up !== 1'b1) begin n_fail++; $display("FAIL clr_setup: got %0d/%0d want 3/1", speed, dir_up); end
    obs_q.delete();
    m_led = 8'd0;
    press(B_START, 10);
    while (m_led != 8'd34) begin
      wait_obs(1, 10, ok);
      if (!ok) begin
        n_checks++; n_fail++; $display("FAIL clr_count: got stall at %0d want 34", m_led);
        break;
      end
      o = obs_q.pop_front();
      n_checks++; if (o.val !== m_led + 8'd1) begin n_fail++; $display("FAIL clr_count_val: got %0d want %0d", o.val, m_led + 8'd1); end
      m_led = m_led + 8'd1;
    end
    exp_q.push_back(8'd35); exp_q.push_back(8'd36); exp_q.push_back(8'd37); exp_q.push_back(8'd0);
    press(B_CLR | B_DIR, 10);
    n_checks++; if (running !== 1'b0) begin n_fail++; $display("FAIL clrdir_running: got %0d want 0", running); end
    n_checks++; if (led_out !== 8'd0) begin n_fail++; $display("FAIL clrdir_led: got %0d want 0", led_out); end
    n_checks++; if (dir_up !== 1'b0) begin n_fail++; $display("FAIL clrdir_dir: got %0d want 0", dir_up); end
    n_checks++; if (speed !== 2'd3) begin n_fail++; $display("FAIL clrdir_speed: got %0d want 3", speed); end
    n_checks++; if (obs_q.size() != 4) begin n_fail++; $display("FAIL clrdir_changes: got %0d want 4", obs_q.size()); end
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front();
      e = exp_q.pop_front();
      n_checks++; if (o.val !== e) begin n_fail++; $display("FAIL clrdir_seq: got %0d want %0d", o.val, e); end
    end
    exp_q.delete();
    obs_q.delete();
    tick_n(10);
  endtask

  task automatic test_reset_midrun();
    press(B_START, 10);
    tick_n(10);
    n_checks++; if (running !== 1'b1) begin n_fail++; $display("FAIL midrun_running: got %0d want 1", running); end
    btn_dir = 1'b1;
    tick_n(3);
    #2 rst = 1'b1;
    #1;
    n_checks++; if (led_out !== 8'd0) begin n_fail++; $display("FAIL async_led: got %0d want 0", led_out); end
    n_checks++; if (running !== 1'b0) begin n_fail++; $display("FAIL async_running: got %0d want 0", running); end
    n_checks++; if (dir_up !== 1'b1) begin n_fail++; $display("FAIL async_dir: got %0d want 1", dir_up); end
    n_checks++; if (speed !== 2'd0) begin n_fail++; $display("FAIL async_speed: got %0d want 0", speed); end
    tick_n(2);
    rst = 1'b0;
    tick_n(6);
    n_checks++; if (dir_up !== 1'b1) begin n_fail++; $display("FAIL deb_discard_early: got %0d want 1", dir_up); end
    tick_n(2);
    n_checks++; if (dir_up !== 1'b0) begin n_fail++; $display("FAIL deb_discard_late: got %0d want 0", dir_up); end
    btn_dir = 1'b0;
    tick_n(10);
  endtask

  initial begin
    rst = 1'b1;
    {btn_start, btn_dir, btn_speed, btn_clr} = 4'b0000;
    @(negedge clk);
    test_reset();
    test_start_run();
    test_debounce_glitch();
    test_wrap();
    test_speed();
    test_pause();
    test_clr_dir();
    test_reset_midrun();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
